pe_array_sequencer: RTL
=======================

// Module: pe_array_sequencer
// PURPOSE
//  Control FSM for one convolution pass on the PE array: resets line buffers, loads one 3x3 filter per PE, primes line buffers, streams the image.
//  Issues per-cycle PE control strobes and flags valid output windows for downstream writeback.
//  Sits between the top-level layer controller (start/config) and the PE array control inputs. Input FIFO data bypasses this block; only valid/ready does not.
// PARAMETERS
//  N_PE     `N_PE       number of PEs; width of shifting_filter
//  ADDR_W   `ADDR_FIFO  width of row_length/num_rows
//  K        3           kernel side; K*K filter taps per PE
//  MAC_LAT  2           cycles from mac_enable beat to PE output valid
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous, active-low reset
//  start            in   1       pulse; begin pass (sampled in IDLE only)
//  abort            in   1       return to IDLE next cycle
//  cfg_row_length   in   ADDR_W  pixels per row
//  cfg_num_rows     in   ADDR_W  rows per channel
//  cfg_final_bank   in   1       last filter bank of layer
//  cfg_nl_type      in   3       non-linearity select
//  cfg_nl_enable    in   1       non-linearity enable
//  in_valid         in   1       input FIFO has a word on the PE input buses
//  in_ready         out  1       sequencer consumes word this cycle
//  busy             out  1       not IDLE
//  done             out  1       1-cycle pulse at pass end
//  cfg_err          out  1       1-cycle pulse, start rejected
//  line_buffer_reset out 1       to PE array
//  shifting_line    out  1       to PE array
//  row_length       out  ADDR_W  latched cfg_row_length
//  shifting_filter  out  N_PE    one-hot filter-load strobe
//  mac_enable       out  1       to PE array
//  adder_enable     out  1       mac_enable delayed 1 cycle
//  final_filter_bank out 1       latched cfg_final_bank
//  nl_type / nl_enable out 3/1   latched config
//  out_valid        out  1       PE outputs hold a valid window this cycle
//  pool_* (5 ports) out  -       see CONFIGURATION
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state IDLE; all outputs 0; latched config 0. Takes effect mid-pass; in-flight delay pipeline cleared.
//  beat = in_valid & in_ready. in_ready = 1 only in FLOAD, FILL, CONV. All counters advance on beat only; no beat means stall, with strobes low.
//  IDLE: on start: if cfg_row_length<K or cfg_num_rows<K, pulse cfg_err and stay in IDLE. Otherwise latch config and go to LBRST.
//  LBRST: line_buffer_reset=1 for exactly 1 cycle, then go to FLOAD.
//  FLOAD: shifting_filter = one-hot(pe_idx) on each beat. tap counter 0..K*K-1; at wrap pe_idx++. After N_PE*K*K beats, go to FILL.
//  FILL: shifting_line=1 on each beat. After (K-1)*row_length+(K-1) beats, go to CONV.
//  CONV: shifting_line=1 and mac_enable=1 on each beat.
//    col counter continues from FILL position and wraps at row_length-1.
//    Beat with col>=K-1 is a valid window; it is tagged into a MAC_LAT-deep delay line that drives out_valid.
//    After num_rows*row_length total streamed beats, go to DRAIN.
//  DRAIN: no beats. Wait MAC_LAT+1 cycles so the last adder_enable and out_valid emerge, then go to DONE.
//  DONE: done=1 for one cycle, then go to IDLE. busy=0 in IDLE only.
//  abort in any state: go to IDLE next cycle, strobes 0, delay line cleared, no done. If abort and start are both high in IDLE, abort wins.
//  start outside IDLE is ignored. Config inputs are sampled only on accepted start.
//  Valid windows per pass = (num_rows-K+1)*(row_length-K+1). Counters are ADDR_W+log2 wide and unsigned, with no overflow inside legal config.
// CONFIGURATION
//  PE_SEQ_POOL_EN defined:
//    pool_enable = shifting_line_pool = out_valid.
//    line_buffer_reset_pool = line_buffer_reset.
//    row_length_pool = row_length-K+1.
//    pool_nl = {cfg_nl_enable, 2'b00} latched.
//  PE_SEQ_POOL_EN undefined: all pool_* outputs tied to 0; no pool logic.
// STRUCTURE
//  header.vh: `N_PE, `ADDR_FIFO, `PE_K, FSM state localparams (IDLE, LBRST, FLOAD, FILL, CONV, DRAIN, DONE).
//  Sub-module pe_seq_delay: parameterised DEPTH shift register with sync clear. Used for out_valid (MAC_LAT) and adder_enable (1).
// TESTING
//  N_PE=4, row=5, rows=4, in_valid=1: 36 FLOAD beats (9 per PE, one-hot 0001..1000), 12 FILL, 8 CONV, 6 out_valid pulses, single done.
//  Same config, in_valid toggling 1/0 every cycle: identical strobe counts and order; no strobe in any in_valid=0 cycle.
//  start with row=2, rows=4: cfg_err=1 for 1 cycle; busy stays 0; no strobes.
//  abort in CONV beat 3: IDLE next cycle, out_valid 0 thereafter, no done. Next start completes normally.
//  rst=0 during FLOAD: all outputs 0 next edge. start after release reruns from LBRST.
//  PE_SEQ_POOL_EN build, row=5: row_length_pool=3; pool_enable pulses coincide with the 6 out_valid pulses.

Source files
------------

// File: rtl/pe_array_sequencer_pkg.sv
// Shared types and sizing for the PE array sequencer.
package pe_array_sequencer_pkg;
  localparam int PE_N_PE    = 4;
  localparam int ADDR_W     = 8;
  localparam int PE_K       = 3;
  localparam int PE_MAC_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LBRST = 3'd1,
    S_FLOAD = 3'd2,
    S_FILL  = 3'd3,
    S_CONV  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] row_length;
    logic [ADDR_W-1:0] num_rows;
    logic              final_bank;
    logic [2:0]        nl_type;
    logic              nl_enable;
  } cfg_t;
endpackage

// File: rtl/pe_array_sequencer_if.sv
// Layer-controller / input-FIFO / PE-array control bundle of the sequencer.
interface pe_array_sequencer_if #(
  parameter int N_PE   = 4,
  parameter int ADDR_W = 8
);
  logic              start, abort;
  logic [ADDR_W-1:0] cfg_row_length, cfg_num_rows;
  logic              cfg_final_bank;
  logic [2:0]        cfg_nl_type;
  logic              cfg_nl_enable;
  logic              in_valid, in_ready;
  logic              busy, done, cfg_err;
  logic              line_buffer_reset, shifting_line;
  logic [ADDR_W-1:0] row_length;
  logic [N_PE-1:0]   shifting_filter;
  logic              mac_enable, adder_enable, final_filter_bank;
  logic [2:0]        nl_type;
  logic              nl_enable, out_valid;
  logic              pool_enable, shifting_line_pool, line_buffer_reset_pool;
  logic [ADDR_W-1:0] row_length_pool;
  logic [2:0]        pool_nl;

  modport master (
    input  start, abort, cfg_row_length, cfg_num_rows, cfg_final_bank, cfg_nl_type,
           cfg_nl_enable, in_valid,
    output in_ready, busy, done, cfg_err, line_buffer_reset, shifting_line, row_length,
           shifting_filter, mac_enable, adder_enable, final_filter_bank, nl_type, nl_enable,
           out_valid, pool_enable, shifting_line_pool, line_buffer_reset_pool,
           row_length_pool, pool_nl
  );
  modport slave (
    output start, abort, cfg_row_length, cfg_num_rows, cfg_final_bank, cfg_nl_type,
           cfg_nl_enable, in_valid,
    input  in_ready, busy, done, cfg_err, line_buffer_reset, shifting_line, row_length,
           shifting_filter, mac_enable, adder_enable, final_filter_bank, nl_type, nl_enable,
           out_valid, pool_enable, shifting_line_pool, line_buffer_reset_pool,
           row_length_pool, pool_nl
  );
endinterface

// File: rtl/pe_seq_delay.sv
// DEPTH-cycle valid delay line with synchronous clear.
module pe_seq_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);
  logic [DEPTH:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= din;
      for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[DEPTH];
endmodule

// File: rtl/pe_array_sequencer.sv
// Convolution-pass control FSM for the PE array: LB reset, filter load, LB prime, stream.
// Optional pooling-side outputs are built when PE_SEQ_POOL_EN is defined.
module pe_array_sequencer
  import pe_array_sequencer_pkg::*;
#(
  parameter int N_PE    = PE_N_PE,
  parameter int MAC_LAT = PE_MAC_LAT
) (
  input logic                  clk,
  input logic                  rst,
  pe_array_sequencer_if.master bus
);
  localparam int PEW  = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int TAPW = $clog2(PE_K*PE_K);
  localparam int CW   = 2*ADDR_W;
  localparam int DW   = $clog2(MAC_LAT+2);
  localparam logic [ADDR_W-1:0] KA = ADDR_W'(PE_K);

  state_t            state, nstate;
  cfg_t              cfg_q;
  logic              cfg_err_q;
  logic [TAPW-1:0]   tap;
  logic [PEW-1:0]    pe_idx;
  logic [CW-1:0]     pix, row_w, fill_end, pass_end;
  logic [ADDR_W-1:0] col;
  logic [DW-1:0]     drain;
  logic              streaming, in_ready_c, beat, cfg_bad, accept;
  logic              tap_last, pe_last, col_last, drain_last;
  logic              lbr_c, done_c, shl_c, mac_c, win_c, add_q, ov_q;
  logic [N_PE-1:0]   sf_c;

  assign streaming  = (state == S_FLOAD) || (state == S_FILL) || (state == S_CONV);
  assign in_ready_c = streaming && !bus.abort;
  assign beat       = in_ready_c && bus.in_valid;
  assign cfg_bad    = (bus.cfg_row_length < KA) || (bus.cfg_num_rows < KA);
  assign accept     = (state == S_IDLE) && bus.start && !bus.abort && !cfg_bad;

  // Streamed-pixel index of the last FILL beat and of the last beat of the pass
  assign row_w      = CW'(cfg_q.row_length);
  assign fill_end   = row_w * CW'(PE_K-1) + CW'(PE_K-2);
  assign pass_end   = row_w * CW'(cfg_q.num_rows) - CW'(1);
  assign tap_last   = tap == TAPW'(PE_K*PE_K-1);
  assign pe_last    = pe_idx == PEW'(N_PE-1);
  assign col_last   = col == cfg_q.row_length - ADDR_W'(1);
  assign drain_last = drain == DW'(MAC_LAT);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (bus.abort) nstate = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (bus.start && !cfg_bad) nstate = S_LBRST;
        S_LBRST: nstate = S_FLOAD;
        S_FLOAD: if (beat && tap_last && pe_last) nstate = S_FILL;
        S_FILL:  if (beat && pix == fill_end) nstate = S_CONV;
        S_CONV:  if (beat && pix == pass_end) nstate = S_DRAIN;
        S_DRAIN: if (drain_last) nstate = S_DONE;
        S_DONE:  nstate = S_IDLE;
        default: nstate = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lbr_c  = (state == S_LBRST) && !bus.abort;
    done_c = (state == S_DONE) && !bus.abort;
    sf_c   = '0;
    if (beat && state == S_FLOAD) sf_c[pe_idx] = 1'b1;
    shl_c  = beat && (state == S_FILL || state == S_CONV);
    mac_c  = beat && (state == S_CONV);
    win_c  = mac_c && (col >= KA - ADDR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst || state == S_LBRST) begin
      tap    <= '0;
      pe_idx <= '0;
      pix    <= '0;
      col    <= '0;
      drain  <= '0;
    end else if (beat) begin
      if (state == S_FLOAD) begin
        tap <= tap_last ? '0 : tap + TAPW'(1);
        if (tap_last) pe_idx <= pe_last ? '0 : pe_idx + PEW'(1);
      end else begin
        // Column keeps running across the FILL/CONV boundary
        pix <= pix + CW'(1);
        col <= col_last ? '0 : col + ADDR_W'(1);
      end
    end else if (state == S_DRAIN) begin
      drain <= drain + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state == S_IDLE) && bus.start && !bus.abort && cfg_bad;
      if (accept)
        cfg_q <= '{row_length: bus.cfg_row_length, num_rows: bus.cfg_num_rows,
                   final_bank: bus.cfg_final_bank, nl_type: bus.cfg_nl_type,
                   nl_enable: bus.cfg_nl_enable};
    end
  end

  pe_seq_delay #(.DEPTH(1)) u_add_dly (
    .clk(clk), .rst(rst), .clr(bus.abort), .din(mac_c), .dout(add_q)
  );
  pe_seq_delay #(.DEPTH(MAC_LAT)) u_ov_dly (
    .clk(clk), .rst(rst), .clr(bus.abort), .din(win_c), .dout(ov_q)
  );

  assign bus.in_ready          = in_ready_c;
  assign bus.busy              = state != S_IDLE;
  assign bus.done              = done_c;
  assign bus.cfg_err           = cfg_err_q;
  assign bus.line_buffer_reset = lbr_c;
  assign bus.shifting_line     = shl_c;
  assign bus.shifting_filter   = sf_c;
  assign bus.mac_enable        = mac_c;
  assign bus.adder_enable      = add_q;
  assign bus.out_valid         = ov_q;
  assign bus.row_length        = cfg_q.row_length;
  assign bus.final_filter_bank = cfg_q.final_bank;
  assign bus.nl_type           = cfg_q.nl_type;
  assign bus.nl_enable         = cfg_q.nl_enable;

`ifdef PE_SEQ_POOL_EN
  logic [ADDR_W-1:0] pool_row_q;

  always_ff @(posedge clk) begin
    if (!rst)        pool_row_q <= '0;
    else if (accept) pool_row_q <= bus.cfg_row_length - (KA - ADDR_W'(1));
  end

  assign bus.pool_enable            = ov_q;
  assign bus.shifting_line_pool     = ov_q;
  assign bus.line_buffer_reset_pool = lbr_c;
  assign bus.row_length_pool        = pool_row_q;
  assign bus.pool_nl                = {cfg_q.nl_enable, 2'b00};
`else
  assign bus.pool_enable            = 1'b0;
  assign bus.shifting_line_pool     = 1'b0;
  assign bus.line_buffer_reset_pool = 1'b0;
  assign bus.row_length_pool        = '0;
  assign bus.pool_nl                = 3'b000;
`endif
endmodule
